// File: rtl/fp_unit_arbiter_pkg.sv
// rtl/fp_unit_arbiter_pkg.sv - shared widths, opcodes and helpers for the FP unit arbiter
package fp_unit_arbiter_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int dataWidth(input int expWidth, input int fracWidth);
      return expWidth + fracWidth;
   endfunction

endpackage

// File: rtl/fp_unit_arbiter_tag_fifo.sv
// rtl/fp_unit_arbiter_tag_fifo.sv - synchronous FIFO holding the owner tag of each in-flight op
module fp_unit_arbiter_tag_fifo
   import fp_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8,
   localparam int AW = clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign count  = wrPtr - rdPtr;
   assign empty  = (wrPtr == rdPtr);
   assign doPush = push && (count != CNT_W'(DEPTH));
   assign doPop  = pop && !empty;
   assign rdData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clkIn) begin
      if (!rstIn) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (AW + 1)'(1);
         if (doPop)  rdPtr <= rdPtr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clkIn) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
   end

endmodule

// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - round-robin sharing of one pipelined FP unit among NUM_REQ requesters
module fp_unit_arbiter
   import fp_unit_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FRAC_WIDTH = 24,
   parameter int EXP_WIDTH  = 8,
   parameter int OP_WIDTH   = 2,
   parameter int LATENCY    = 4,
   parameter int TAG_DEPTH  = 8,
   localparam int DATA_WIDTH = dataWidth(EXP_WIDTH, FRAC_WIDTH),
   localparam int TAG_WIDTH  = clog2(NUM_REQ)
) (
   input  logic                           clkIn,
   input  logic                           rstIn,
   input  logic [NUM_REQ-1:0]             reqValidIn,
   output logic [NUM_REQ-1:0]             reqReadyOut,
   input  logic [NUM_REQ*OP_WIDTH-1:0]    reqOpIn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  reqAIn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  reqBIn,
   output logic                           unitValidOut,
   output logic [OP_WIDTH-1:0]            unitOpOut,
   output logic [DATA_WIDTH-1:0]          unitAOut,
   output logic [DATA_WIDTH-1:0]          unitBOut,
   input  logic                           unitValidIn,
   input  logic [DATA_WIDTH-1:0]          unitDataIn,
   output logic [NUM_REQ-1:0]             respValidOut,
   output logic [DATA_WIDTH-1:0]          respDataOut,
   output logic                           busyOut,
   output logic                           errorOut
);

   localparam int CNT_W   = clog2(TAG_DEPTH) + 1;
   localparam int AGE_W   = clog2(LATENCY + 4) + 1;
   localparam int DRAIN_W = clog2(LATENCY + 2) + 1;

   logic [TAG_WIDTH-1:0] ptr;
   logic [TAG_WIDTH-1:0] grantIdx;
   logic [TAG_WIDTH-1:0] cand;
   logic [TAG_WIDTH-1:0] headTag;
   logic                 grantValid;
   logic                 eligible;
   logic                 handshake;
   logic                 fifoEmpty;
   logic                 pop;
   logic                 stale;
   logic                 spurious;
   logic [CNT_W-1:0]     tagCount;
   logic [AGE_W-1:0]     headAge;
   logic [DRAIN_W-1:0]   drainCnt;

   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = TAG_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (!grantValid && reqValidIn[cand]) begin
            grantValid = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   assign eligible    = (tagCount < CNT_W'(TAG_DEPTH));
   assign reqReadyOut = (rstIn && eligible && grantValid) ? (NUM_REQ'(1) << grantIdx) : '0;
   assign handshake   = |(reqValidIn & reqReadyOut);
   assign pop         = unitValidIn && !fifoEmpty;
   assign spurious    = unitValidIn && fifoEmpty && (drainCnt == '0);
   // Only the head is aged; a younger entry cannot time out before the one ahead of it.
   assign stale       = !fifoEmpty && !unitValidIn && (headAge >= AGE_W'(LATENCY + 2));
   assign busyOut     = !fifoEmpty || unitValidOut;

   fp_unit_arbiter_tag_fifo #(
      .WIDTH (TAG_WIDTH),
      .DEPTH (TAG_DEPTH)
   ) tagFifo (
      .clkIn  (clkIn),
      .rstIn  (rstIn),
      .push   (handshake),
      .wrData (grantIdx),
      .pop    (pop),
      .rdData (headTag),
      .empty  (fifoEmpty),
      .count  (tagCount)
   );

   always_ff @(posedge clkIn) begin
      if (!rstIn) begin
         ptr          <= '0;
         unitValidOut <= 1'b0;
         unitOpOut    <= '0;
         unitAOut     <= '0;
         unitBOut     <= '0;
         respValidOut <= '0;
         respDataOut  <= '0;
         errorOut     <= 1'b0;
         headAge      <= '0;
         drainCnt     <= DRAIN_W'(LATENCY + 1);
      end else begin
         unitValidOut <= handshake;
         if (handshake) begin
            ptr       <= (grantIdx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grantIdx + TAG_WIDTH'(1);
            unitOpOut <= reqOpIn[grantIdx*OP_WIDTH +: OP_WIDTH];
            unitAOut  <= reqAIn[grantIdx*DATA_WIDTH +: DATA_WIDTH];
            unitBOut  <= reqBIn[grantIdx*DATA_WIDTH +: DATA_WIDTH];
         end
         respValidOut <= pop ? (NUM_REQ'(1) << headTag) : '0;
         if (pop) respDataOut <= unitDataIn;
         if (spurious || stale) errorOut <= 1'b1;
         // Results of ops issued before reset are swallowed during this window.
         if (drainCnt != '0) drainCnt <= drainCnt - DRAIN_W'(1);
         if (fifoEmpty || pop) headAge <= '0;
         else if (headAge != '1) headAge <= headAge + AGE_W'(1);
      end
   end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb/tb_fp_unit_arbiter.sv - directed self-checking bench for fp_unit_arbiter
module tb_fp_unit_arbiter;

   logic         clkIn;
   logic         rstIn;
   logic [3:0]   reqValidIn;
   logic [3:0]   reqReadyOut;
   logic [7:0]   reqOpIn;
   logic [127:0] reqAIn;
   logic [127:0] reqBIn;
   logic         unitValidOut;
   logic [1:0]   unitOpOut;
   logic [31:0]  unitAOut;
   logic [31:0]  unitBOut;
   logic         unitValidIn;
   logic [31:0]  unitDataIn;
   logic [3:0]   respValidOut;
   logic [31:0]  respDataOut;
   logic         busyOut;
   logic         errorOut;

   int total;
   int bad;

   fp_unit_arbiter dut (
      .clkIn        (clkIn),
      .rstIn        (rstIn),
      .reqValidIn   (reqValidIn),
      .reqReadyOut  (reqReadyOut),
      .reqOpIn      (reqOpIn),
      .reqAIn       (reqAIn),
      .reqBIn       (reqBIn),
      .unitValidOut (unitValidOut),
      .unitOpOut    (unitOpOut),
      .unitAOut     (unitAOut),
      .unitBOut     (unitBOut),
      .unitValidIn  (unitValidIn),
      .unitDataIn   (unitDataIn),
      .respValidOut (respValidOut),
      .respDataOut  (respDataOut),
      .busyOut      (busyOut),
      .errorOut     (errorOut)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   task automatic doReset();
      rstIn       = 1'b0;
      reqValidIn  = '0;
      unitValidIn = 1'b0;
      unitDataIn  = '0;
      repeat (2) @(negedge clkIn);
      rstIn = 1'b1;
   endtask

   task automatic test_reset();
      rstIn       = 1'b0;
      reqValidIn  = 4'hF;
      unitValidIn = 1'b0;
      unitDataIn  = '0;
      repeat (2) @(negedge clkIn);
      #1;
      total++; if (reqReadyOut !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", reqReadyOut); end
      total++; if (unitValidOut !== 1'b0) begin bad++; $display("FAIL reset_unit_valid got=%b exp=0", unitValidOut); end
      total++; if (unitAOut !== 32'h0) begin bad++; $display("FAIL reset_unit_a got=%h exp=0", unitAOut); end
      total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0000", respValidOut); end
      total++; if (respDataOut !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", respDataOut); end
      total++; if (busyOut !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busyOut); end
      total++; if (errorOut !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", errorOut); end
      reqValidIn = '0;
   endtask

   task automatic test_single();
      doReset();
      reqAIn[32 +: 32] = 32'h3F800000;
      reqBIn[32 +: 32] = 32'h40000000;
      for (int c = 0; c < 8; c++) begin
         @(negedge clkIn);
         reqValidIn  = (c == 0) ? 4'b0010 : 4'b0000;
         unitValidIn = (c == 5);
         unitDataIn  = (c == 5) ? 32'h40400000 : 32'h0;
         #1;
         if (c == 0) begin
            total++; if (reqReadyOut !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", reqReadyOut); end
         end
         if (c == 1) begin
            total++; if (unitValidOut !== 1'b1) begin bad++; $display("FAIL single_issue_valid got=%b exp=1", unitValidOut); end
            total++; if (unitAOut !== 32'h3F800000) begin bad++; $display("FAIL single_issue_a got=%h exp=3f800000", unitAOut); end
            total++; if (unitBOut !== 32'h40000000) begin bad++; $display("FAIL single_issue_b got=%h exp=40000000", unitBOut); end
            total++; if (unitOpOut !== 2'd0) begin bad++; $display("FAIL single_issue_op got=%0d exp=0", unitOpOut); end
            total++; if (busyOut !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busyOut); end
         end
         if (c == 2) begin
            total++; if (unitValidOut !== 1'b0) begin bad++; $display("FAIL single_issue_drop got=%b exp=0", unitValidOut); end
         end
         if (c == 5) begin
            total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL single_resp_early got=%b exp=0000", respValidOut); end
         end
         if (c == 6) begin
            total++; if (respValidOut !== 4'b0010) begin bad++; $display("FAIL single_resp_valid got=%b exp=0010", respValidOut); end
            total++; if (respDataOut !== 32'h40400000) begin bad++; $display("FAIL single_resp_data got=%h exp=40400000", respDataOut); end
            total++; if (busyOut !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", busyOut); end
         end
         if (c == 7) begin
            total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL single_resp_pulse got=%b exp=0000", respValidOut); end
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  expGrant;
      logic [31:0] expData;
      doReset();
      for (int i = 0; i < 4; i++) begin
         reqAIn[i*32 +: 32] = 32'h41000000 + 32'(i);
         reqBIn[i*32 +: 32] = 32'h42000000 + 32'(i);
      end
      for (int c = 0; c < 16; c++) begin
         @(negedge clkIn);
         reqValidIn  = (c < 8) ? 4'hF : 4'h0;
         unitValidIn = (c >= 5 && c < 13);
         unitDataIn  = 32'h100 + 32'(c - 5);
         #1;
         if (c < 8) begin
            expGrant = 4'b0001 << (c % 4);
            total++; if (reqReadyOut !== expGrant) begin bad++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, reqReadyOut, expGrant); end
         end
         if (c >= 1 && c <= 8) begin
            expData = 32'h41000000 + 32'((c - 1) % 4);
            total++; if (unitAOut !== expData || unitValidOut !== 1'b1) begin bad++; $display("FAIL rr_issue c=%0d got=%h/%b exp=%h/1", c, unitAOut, unitValidOut, expData); end
         end
         if (c >= 6 && c <= 13) begin
            expGrant = 4'b0001 << ((c - 6) % 4);
            expData  = 32'h100 + 32'(c - 6);
            total++; if (respValidOut !== expGrant || respDataOut !== expData) begin bad++; $display("FAIL rr_resp c=%0d got=%b/%h exp=%b/%h", c, respValidOut, respDataOut, expGrant, expData); end
         end
         if (c == 15) begin
            total++; if (errorOut !== 1'b0) begin bad++; $display("FAIL rr_error got=%b exp=0", errorOut); end
         end
      end
   endtask

   task automatic test_full();
      logic [3:0] expGrant;
      doReset();
      for (int c = 0; c < 11; c++) begin
         @(negedge clkIn);
         reqValidIn  = 4'hF;
         unitValidIn = (c == 9);
         unitDataIn  = (c == 9) ? 32'h55 : 32'h0;
         #1;
         if (c < 8) begin
            expGrant = 4'b0001 << (c % 4);
            total++; if (reqReadyOut !== expGrant) begin bad++; $display("FAIL full_fill c=%0d got=%b exp=%b", c, reqReadyOut, expGrant); end
         end
         if (c == 8 || c == 9) begin
            total++; if (reqReadyOut !== 4'b0000) begin bad++; $display("FAIL full_stall c=%0d got=%b exp=0000", c, reqReadyOut); end
            total++; if (busyOut !== 1'b1) begin bad++; $display("FAIL full_busy c=%0d got=%b exp=1", c, busyOut); end
         end
         if (c == 10) begin
            total++; if (reqReadyOut !== 4'b0001) begin bad++; $display("FAIL full_resume got=%b exp=0001", reqReadyOut); end
            total++; if (respValidOut !== 4'b0001 || respDataOut !== 32'h55) begin bad++; $display("FAIL full_resp got=%b/%h exp=0001/00000055", respValidOut, respDataOut); end
         end
      end
      reqValidIn = '0;
   endtask

   task automatic test_spurious();
      doReset();
      for (int c = 0; c < 18; c++) begin
         @(negedge clkIn);
         unitValidIn = (c == 10);
         unitDataIn  = 32'hDEAD0000;
         #1;
         if (c == 10) begin
            total++; if (errorOut !== 1'b0) begin bad++; $display("FAIL spur_before got=%b exp=0", errorOut); end
         end
         if (c == 11) begin
            total++; if (errorOut !== 1'b1) begin bad++; $display("FAIL spur_error got=%b exp=1", errorOut); end
            total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL spur_resp got=%b exp=0000", respValidOut); end
         end
         if (c == 17) begin
            total++; if (errorOut !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", errorOut); end
         end
      end
      @(negedge clkIn);
      rstIn = 1'b0;
      @(negedge clkIn);
      #1;
      total++; if (errorOut !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b exp=0", errorOut); end
      rstIn = 1'b1;
   endtask

   task automatic test_reset_in_flight();
      doReset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clkIn);
         reqValidIn  = (c < 3) ? 4'b0001 : 4'b0000;
         rstIn       = (c == 3) ? 1'b0 : 1'b1;
         unitValidIn = (c >= 4 && c <= 6);
         unitDataIn  = 32'h3F000000;
         #1;
         if (c == 2) begin
            total++; if (busyOut !== 1'b1) begin bad++; $display("FAIL rif_busy_before got=%b exp=1", busyOut); end
         end
         if (c == 4) begin
            total++; if (busyOut !== 1'b0 || unitValidOut !== 1'b0) begin bad++; $display("FAIL rif_cleared got=%b/%b exp=0/0", busyOut, unitValidOut); end
         end
         if (c >= 5 && c <= 7) begin
            total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL rif_resp c=%0d got=%b exp=0000", c, respValidOut); end
         end
         if (c == 8) begin
            total++; if (errorOut !== 1'b0 || busyOut !== 1'b0) begin bad++; $display("FAIL rif_final got=%b/%b exp=0/0", errorOut, busyOut); end
         end
      end
   endtask

   task automatic test_nan_and_timeout();
      doReset();
      for (int c = 0; c < 17; c++) begin
         @(negedge clkIn);
         reqValidIn  = (c == 0) ? 4'b0100 : (c == 7) ? 4'b1000 : 4'b0000;
         unitValidIn = (c == 5);
         unitDataIn  = (c == 5) ? 32'h7FC00001 : 32'h0;
         #1;
         if (c == 0) begin
            total++; if (reqReadyOut !== 4'b0100) begin bad++; $display("FAIL nan_grant got=%b exp=0100", reqReadyOut); end
         end
         if (c == 6) begin
            total++; if (respValidOut !== 4'b0100 || respDataOut !== 32'h7FC00001) begin bad++; $display("FAIL nan_resp got=%b/%h exp=0100/7fc00001", respValidOut, respDataOut); end
         end
         if (c == 7) begin
            total++; if (reqReadyOut !== 4'b1000) begin bad++; $display("FAIL nan_grant2 got=%b exp=1000", reqReadyOut); end
         end
         if (c == 13) begin
            total++; if (errorOut !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", errorOut); end
         end
         if (c == 16) begin
            total++; if (errorOut !== 1'b1) begin bad++; $display("FAIL timeout_error got=%b exp=1", errorOut); end
            total++; if (respValidOut !== 4'b0000) begin bad++; $display("FAIL timeout_resp got=%b exp=0000", respValidOut); end
         end
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rstIn      = 1'b0;
      reqValidIn = '0;
      reqOpIn    = 8'b00_01_00_10;
      reqAIn     = '0;
      reqBIn     = '0;
      unitValidIn = 1'b0;
      unitDataIn  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_spurious();
      test_reset_in_flight();
      test_nan_and_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
